// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC sequencing controller.
// Contents:
//   mac_ctrl_state_t : controller FSM states
//   DATA_W / ACC_W   : operand and accumulator widths
//   cnt_w(len)       : width of a counter that must hold the value len
package mac_ctrl_pkg;

    typedef enum logic [1:0] {
        FEED   = 2'd0,
        WAIT   = 2'd1,
        CLEAR  = 2'd2,
        RESULT = 2'd3
    } mac_ctrl_state_t;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/mac_evt_counter.sv
// Event up-counter with synchronous clear and terminal-count compare.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   clr   : zero the count (wins over inc)
//   inc   : count one event this cycle
//   last  : the current count is TERM-1, so an event now reaches TERM
module mac_evt_counter #(
    parameter int W    = 3,
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam logic [W:0] TERM_V = (W + 1)'(TERM);

    logic [W-1:0] cnt_q, cnt_d;

    // One extra bit so cnt_q+1 cannot wrap before the compare.
    assign last = ({1'b0, cnt_q} + (W + 1)'(1)) == TERM_V;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_dot_ctrl.sv
// Sequencing controller for a signed 8x8->16 MAC: forwards LEN operand
// pairs, waits for the MAC to drain, captures the dot product and its
// overflow flag, presents them on a valid/ready port, then clears the MAC.
// Ports:
//   clk, reset                : clock, synchronous active-low reset
//   in_valid/in_ready/in_a/b  : operand pair stream
//   out_valid/out_ready       : result handshake
//   out_data/out_ovf          : captured dot product and overflow flag
//   mac_a/mac_b/mac_valid_in  : operand pass-through to the MAC
//   mac_clr                   : MAC active-high clear
//   mac_f/mac_valid_out/mac_overflow : MAC outputs
module mac_dot_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_ovf,
    output logic signed [DATA_W-1:0] mac_a,
    output logic signed [DATA_W-1:0] mac_b,
    output logic                     mac_valid_in,
    output logic                     mac_clr,
    input  logic signed [ACC_W-1:0]  mac_f,
    input  logic                     mac_valid_out,
    input  logic                     mac_overflow
);

    localparam int CW = cnt_w(LEN);

    mac_ctrl_state_t state_q, state_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_ovf_q, out_ovf_d;

    logic accept;
    logic out_evt;
    logic in_last;
    logic out_last;

    assign in_ready     = (state_q == FEED);
    assign out_valid    = (state_q == CLEAR) || (state_q == RESULT);
    assign accept       = in_valid && in_ready;
    assign mac_a        = in_a;
    assign mac_b        = in_b;
    assign mac_valid_in = accept;
    // Holding the MAC in clear during our own reset drops any in-flight
    // pairs of an abandoned vector.
    assign mac_clr      = !reset || (state_q == CLEAR);
    assign out_data     = out_data_q;
    assign out_ovf      = out_ovf_q;

    // Early results of a vector emerge while later pairs are still being
    // fed, so MAC pulses count in FEED as well as WAIT.
    assign out_evt = mac_valid_out && ((state_q == FEED) || (state_q == WAIT));

    // Both counters are held at zero while a result is presented, which
    // leaves them zero on the first FEED cycle of the next vector.
    mac_evt_counter #(.W(CW), .TERM(LEN)) u_cnt_in (
        .clk   (clk),
        .reset (reset),
        .clr   (out_valid),
        .inc   (accept),
        .last  (in_last)
    );

    mac_evt_counter #(.W(CW), .TERM(LEN)) u_cnt_out (
        .clk   (clk),
        .reset (reset),
        .clr   (out_valid),
        .inc   (out_evt),
        .last  (out_last)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            FEED: begin
                if (accept && in_last) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (out_evt && out_last) begin
                    out_data_d = mac_f;
                    out_ovf_d  = mac_overflow;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                state_d = out_ready ? FEED : RESULT;
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = FEED;
                end
            end
            default: state_d = FEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FEED;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
module tb_mac_dot_ctrl;

    localparam int LEN = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_a = '0;
    logic signed [7:0] in_b = '0;
    logic              out_ready = 1'b1;
    logic              in_ready;
    logic              out_valid;
    logic signed [15:0] out_data;
    logic              out_ovf;
    logic signed [7:0] mac_a;
    logic signed [7:0] mac_b;
    logic              mac_valid_in;
    logic              mac_clr;
    logic signed [15:0] mac_f;
    logic              mac_valid_out;
    logic              mac_overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int va[LEN];
    int vb[LEN];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_dot_ctrl #(.LEN(LEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ovf       (out_ovf),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_clr       (mac_clr),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .mac_overflow  (mac_overflow)
    );

    // Behavioural MAC: two-cycle latency, 16-bit wrapping accumulator,
    // sticky signed overflow, synchronous active-high clear.
    logic signed [7:0]  m1_a = '0;
    logic signed [7:0]  m1_b = '0;
    logic               m1_v = 1'b0;
    logic signed [15:0] m_acc = '0;
    logic               m_ovf = 1'b0;
    logic               m_vout = 1'b0;
    int                 m_sum;

    assign m_sum         = int'(m_acc) + int'(m1_a) * int'(m1_b);
    assign mac_f         = m_acc;
    assign mac_valid_out = m_vout;
    assign mac_overflow  = m_ovf;

    always @(posedge clk) begin
        if (mac_clr) begin
            m1_v   <= 1'b0;
            m_vout <= 1'b0;
            m_acc  <= '0;
            m_ovf  <= 1'b0;
        end else begin
            m1_v   <= mac_valid_in;
            m1_a   <= mac_a;
            m1_b   <= mac_b;
            m_vout <= m1_v;
            if (m1_v) begin
                m_acc <= 16'(m_sum);
                if (m_sum > 32767 || m_sum < -32768) m_ovf <= 1'b1;
            end
        end
    end

    // Reference: dot product of va/vb with 16-bit wrap and sticky overflow.
    function automatic void ref_dot(output int d, output bit o);
        int acc;
        int s;
        logic signed [15:0] w;
        acc = 0;
        o = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            s = acc + va[i] * vb[i];
            if (s > 32767 || s < -32768) o = 1'b1;
            w = 16'(s);
            acc = int'(w);
        end
        d = acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed va/vb, idling in_valid with probability bubble%. Returns the
    // cycle of the last accept; leaves time at that cycle + 1.
    task automatic send_vector(input int bubble, output int t_last, output bit to);
        int i;
        int guard;
        bit acc;
        int tnow;
        i = 0;
        guard = 0;
        t_last = 0;
        while (i < LEN && guard < 200) begin
            in_a = 8'(va[i]);
            in_b = 8'(vb[i]);
            in_valid = ($urandom_range(99) >= bubble);
            acc = in_valid && in_ready;
            tnow = cyc;
            step();
            if (acc) begin
                i++;
                t_last = tnow;
            end
            guard++;
        end
        in_valid = 1'b0;
        to = (i < LEN);
    endtask

    task automatic wait_valid(output int t, output bit to);
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            step();
            g++;
        end
        t = cyc;
        to = !out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
        checks++; if (mac_clr !== 1'b1) begin failures++; $display("FAIL reset_mac_clr got=%b exp=1", mac_clr); end
        reset = 1'b1;
        #1;
        checks++; if (mac_clr !== 1'b0) begin failures++; $display("FAIL release_mac_clr got=%b exp=0", mac_clr); end
        step();
    endtask

    task automatic test_basic();
        int t_last, t_v;
        bit to;
        va = '{1, 2, 3, 4};
        vb = '{2, 2, 2, 2};
        out_ready = 1'b1;
        send_vector(0, t_last, to);
        checks++; if (to) begin failures++; $display("FAIL basic_feed_timeout got=1 exp=0"); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_wait_in_ready got=%b exp=0", in_ready); end
        wait_valid(t_v, to);
        checks++; if (to || t_v != t_last + 3) begin failures++; $display("FAIL basic_valid_cycle got=%0d exp=%0d", t_v - t_last, 3); end
        checks++; if (out_data !== 16'sd20) begin failures++; $display("FAIL basic_data got=%0d exp=20", out_data); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
        checks++; if (mac_clr !== 1'b1) begin failures++; $display("FAIL basic_clear got=%b exp=1", mac_clr); end
        step();
        checks++; if (in_ready !== 1'b1 || cyc != t_last + 4) begin failures++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'sd20) begin failures++; $display("FAIL basic_data_held got=%0d exp=20", out_data); end
    endtask

    task automatic test_signed();
        int t_last, t_v;
        bit to;
        va = '{-3, 5, -7, 1};
        vb = '{5, -2, 3, -8};
        send_vector(0, t_last, to);
        wait_valid(t_v, to);
        checks++; if (to || out_data !== -16'sd54) begin failures++; $display("FAIL signed_data got=%0d exp=-54", out_data); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL signed_ovf got=%b exp=0", out_ovf); end
        step();
    endtask

    task automatic test_overflow();
        int t_last, t_v, d;
        bit to, o;
        va = '{127, 127, 127, 127};
        vb = '{127, 127, 127, 127};
        ref_dot(d, o);
        send_vector(0, t_last, to);
        wait_valid(t_v, to);
        checks++; if (to || out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", out_ovf); end
        checks++; if (int'(out_data) != d) begin failures++; $display("FAIL ovf_data got=%0d exp=%0d", out_data, d); end
        step();
        va = '{1, 1, 1, 1};
        vb = '{1, 1, 1, 1};
        send_vector(0, t_last, to);
        wait_valid(t_v, to);
        checks++; if (to || out_data !== 16'sd4) begin failures++; $display("FAIL ovf_cleared_data got=%0d exp=4", out_data); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared_flag got=%b exp=0", out_ovf); end
        step();
    endtask

    task automatic test_backpressure();
        int t_last, t_v;
        bit to;
        va = '{6, -1, 2, 0};
        vb = '{7, 4, -9, 100};
        out_ready = 1'b0;
        send_vector(0, t_last, to);
        wait_valid(t_v, to);
        checks++; if (to || t_v != t_last + 3) begin failures++; $display("FAIL bp_valid_cycle got=%0d exp=3", t_v - t_last); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 16'sd20 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got=v%b d%0d r%b exp=v1 d20 r0", k, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_release_cycle got=v%b r%b exp=v1 r0", out_valid, in_ready); end
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_ready got=r%b v%b exp=r1 v0", in_ready, out_valid); end
        checks++; if (out_data !== 16'sd20) begin failures++; $display("FAIL bp_data_kept got=%0d exp=20", out_data); end
    endtask

    task automatic test_bubbles();
        int t_last, t_v;
        bit to;
        va = '{10, 20, 30, 40};
        vb = '{1, 1, 1, 1};
        send_vector(50, t_last, to);
        wait_valid(t_v, to);
        checks++; if (to || t_v != t_last + 3) begin failures++; $display("FAIL bubble_drain got=%0d exp=3", t_v - t_last); end
        checks++; if (out_data !== 16'sd100) begin failures++; $display("FAIL bubble_data got=%0d exp=100", out_data); end
        step();
    endtask

    task automatic test_reset_mid();
        int t_last, t_v, n, g;
        bit to;
        n = 0;
        g = 0;
        in_a = 8'sd9;
        in_b = 8'sd9;
        while (n < 2 && g < 20) begin
            in_valid = 1'b1;
            if (in_ready) n++;
            step();
            g++;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (mac_clr !== 1'b1) begin failures++; $display("FAIL midrst_mac_clr got=%b exp=1", mac_clr); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mac_clr !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release got=r%b v%b c%b exp=r1 v0 c0", in_ready, out_valid, mac_clr);
        end
        va = '{3, 3, 3, 3};
        vb = '{1, 1, 1, 1};
        send_vector(0, t_last, to);
        wait_valid(t_v, to);
        checks++; if (to || t_v != t_last + 3) begin failures++; $display("FAIL midrst_timing got=%0d exp=3", t_v - t_last); end
        checks++; if (out_data !== 16'sd12 || out_ovf !== 1'b0) begin failures++; $display("FAIL midrst_data got=%0d/%b exp=12/0", out_data, out_ovf); end
        step();
    endtask

    task automatic test_random();
        int t_last, t_v, d;
        bit to, o;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < LEN; i++) begin
                va[i] = int'($urandom_range(255)) - 128;
                vb[i] = int'($urandom_range(255)) - 128;
            end
            ref_dot(d, o);
            send_vector(30, t_last, to);
            wait_valid(t_v, to);
            checks++; if (to || t_v != t_last + 3) begin failures++; $display("FAIL rand%0d_timing got=%0d exp=3", v, t_v - t_last); end
            checks++; if (int'(out_data) != d || out_ovf !== o) begin
                failures++;
                $display("FAIL rand%0d_result got=%0d/%b exp=%0d/%b", v, out_data, out_ovf, d, o);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
